button_bounce_gen: RTL and testbench

BUTTON_BOUNCE_GEN -- requirements
Module: button_bounce_gen

---
 rtl/button_bounce_pkg.sv | 22 ++
 rtl/bounce_lfsr.sv | 27 ++
 rtl/button_bounce_gen.sv | 124 ++++++++++++
 tb/tb_button_bounce_gen.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_bounce_pkg.sv
// Shared FSM encoding and LFSR constants for button_bounce_gen.
package button_bounce_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_MASK         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // state  | meaning
  // IDLE   | outputs stable, watching press_i against the settled state
  // BOUNCE | emitting glitch segments on the switch line
  // SETTLE | switch line at its final level, waiting out the debounce window
  typedef logic [1:0] bb_state_t;
  localparam bb_state_t ST_IDLE   = 2'd0;
  localparam bb_state_t ST_BOUNCE = 2'd1;
  localparam bb_state_t ST_SETTLE = 2'd2;

  // An all-zero Galois LFSR is stuck, so a zero seed is promoted to 1.
  function automatic logic [LFSR_W-1:0] lfsr_fix_seed(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) used to randomise bounce segment lengths.
module bounce_lfsr
  import button_bounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_en,
  output logic [LFSR_W-1:0] o_value
);

  localparam logic [LFSR_W-1:0] SEED_EFF = lfsr_fix_seed(SEED);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr <= SEED_EFF;
    end else if (i_en) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_MASK : '0);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/button_bounce_gen.sv
// Mechanical push-button emulator: glitch burst, then a settled level longer than the debounce window.
// Define BUTTON_BOUNCE_GEN_LFSR_EN for pseudo-random segment lengths; otherwise segments are fixed.
module button_bounce_gen
  import button_bounce_pkg::*;
#(
  parameter int          BOUNCES       = 4,
  parameter int          HOLD_W        = 4,
  parameter int          SETTLE_CYCLES = 1100,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic press_i,
  output logic sw_o,
  output logic state_o,
  output logic busy_o,
  output logic done_o
);

  localparam int TGL_W = (BOUNCES > 0) ? $clog2(2 * BOUNCES + 1) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [TGL_W-1:0] TGL_LAST   = TGL_W'(2 * BOUNCES);
  localparam logic [SET_W-1:0] SET_RELOAD = (SETTLE_CYCLES > 0) ? SET_W'(SETTLE_CYCLES - 1) : '0;

  // Hold counter holds (segment length - 1) so it never needs a value of 2^HOLD_W.
  logic [HOLD_W-1:0] w_hold_reload;

`ifdef BUTTON_BOUNCE_GEN_LFSR_EN
  logic [LFSR_W-1:0] w_lfsr;
  logic [LFSR_W-1:0] w_unused_lfsr;

  bounce_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_en   (1'b1),
    .o_value(w_lfsr)
  );

  assign w_hold_reload = w_lfsr[HOLD_W-1:0];
  assign w_unused_lfsr = w_lfsr;
`else
  logic [LFSR_W-1:0] w_unused_seed;

  assign w_hold_reload = HOLD_W'((1 << (HOLD_W - 1)) - 1);
  assign w_unused_seed = LFSR_SEED;
`endif

  bb_state_t         r_state;
  logic              r_target;
  logic              r_sw;
  logic              r_level;
  logic              r_busy;
  logic              r_done;
  logic [HOLD_W-1:0] r_hold;
  logic [TGL_W-1:0]  r_tgl;
  logic [SET_W-1:0]  r_settle;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_target <= 1'b0;
      r_sw     <= 1'b1;
      r_level  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hold   <= '0;
      r_tgl    <= '0;
      r_settle <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (press_i != r_level) begin
            r_target <= press_i;
            r_busy   <= 1'b1;
            if (BOUNCES == 0) begin
              r_state  <= ST_SETTLE;
              r_sw     <= ~press_i;
              r_settle <= SET_RELOAD;
            end else begin
              r_state <= ST_BOUNCE;
              r_sw    <= ~r_sw;
              r_hold  <= w_hold_reload;
              r_tgl   <= TGL_W'(1);
            end
          end
        end
        ST_BOUNCE: begin
          if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
          end else if (r_tgl == TGL_LAST) begin
            // Even toggle count: line is back at the old level, now make the real transition.
            r_state  <= ST_SETTLE;
            r_sw     <= ~r_target;
            r_settle <= SET_RELOAD;
          end else begin
            r_sw   <= ~r_sw;
            r_tgl  <= r_tgl + 1'b1;
            r_hold <= w_hold_reload;
          end
        end
        ST_SETTLE: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_level <= r_target;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sw_o    = r_sw;
  assign state_o = r_level;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Bench for button_bounce_gen: schedule-based reference model, per-cycle compare, debouncer observer.
module tb_button_bounce_gen;

  localparam int HOLD_W = 4;
  localparam int SETTLE = 1100;
  localparam int BA     = 2;
  localparam int BZ     = 0;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int LIMIT  = 3000;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b1;
  logic press_a = 1'b0;
  logic press_z = 1'b0;
  logic sw_a, state_a, busy_a, done_a;
  logic sw_z, state_z, busy_z, done_z;

  always #5 clk_i = ~clk_i;

  button_bounce_gen #(
    .BOUNCES(BA), .HOLD_W(HOLD_W), .SETTLE_CYCLES(SETTLE), .LFSR_SEED(SEED)
  ) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .press_i(press_a),
    .sw_o(sw_a), .state_o(state_a), .busy_o(busy_a), .done_o(done_a)
  );

  button_bounce_gen #(
    .BOUNCES(BZ), .HOLD_W(HOLD_W), .SETTLE_CYCLES(SETTLE), .LFSR_SEED(SEED)
  ) dut_z (
    .clk_i(clk_i), .rst_i(rst_i), .press_i(press_z),
    .sw_o(sw_z), .state_o(state_z), .busy_o(busy_z), .done_o(done_z)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout after %0d cycles waiting for done_o t=%0t", name, LIMIT, $time);
  endtask

  // Reference model: a transition is a precomputed timeline of segment boundaries.
  bit          m_sw[2], m_state[2], m_busy[2], m_done[2], m_target[2];
  int          m_t[2], m_bend[2], m_total[2], m_nb[2];
  int          m_bnd[2][0:31];
  logic [15:0] m_lfsr;
  int          m_presses = 0, m_releases = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sw[d] = 1'b1; m_state[d] = 1'b0; m_busy[d] = 1'b0; m_done[d] = 1'b0;
      m_t[d] = 0;
    end
    m_lfsr = (SEED == 16'h0000) ? 16'h0001 : SEED;
  endtask

  task automatic model_start(input int d, input bit p);
    int acc;
    int len;
`ifdef BUTTON_BOUNCE_GEN_LFSR_EN
    logic [15:0] v;
    int off;
    v   = m_lfsr;
    off = 0;
`endif
    acc = 0;
    m_target[d] = p;
    m_busy[d]   = 1'b1;
    m_t[d]      = 0;
    m_nb[d]     = (d == 0) ? 2 * BA : 2 * BZ;
    for (int k = 0; k < m_nb[d]; k++) begin
`ifdef BUTTON_BOUNCE_GEN_LFSR_EN
      while (off < acc) begin
        v = lfsr_next(v);
        off++;
      end
      len = int'(v[HOLD_W-1:0]) + 1;
`else
      len = 1 << (HOLD_W - 1);
`endif
      acc += len;
      m_bnd[d][k] = acc;
    end
    m_bend[d]  = acc;
    m_total[d] = acc + SETTLE;
  endtask

  function automatic bit model_level(input int d, input int t);
    if (t >= m_bend[d]) return ~m_target[d];
    for (int k = 0; k < m_nb[d]; k++)
      if (t < m_bnd[d][k]) return (k % 2 == 0) ? m_state[d] : ~m_state[d];
    return ~m_target[d];
  endfunction

  task automatic model_edge(input int d, input bit p);
    m_done[d] = 1'b0;
    if (!m_busy[d]) begin
      if (p != m_state[d]) begin
        model_start(d, p);
        m_sw[d] = model_level(d, 0);
      end
    end else begin
      m_t[d]++;
      if (m_t[d] == m_total[d]) begin
        m_state[d] = m_target[d];
        m_done[d]  = 1'b1;
        m_busy[d]  = 1'b0;
        if (d == 0) begin
          if (m_target[d]) m_presses++;
          else m_releases++;
        end
      end else begin
        m_sw[d] = model_level(d, m_t[d]);
      end
    end
  endtask

  // Debouncer observer on dut_a: a level counts once it is stable for 2^10 cycles.
  logic db_last = 1'b1, db_state = 1'b1;
  int   db_cnt = 0, downs = 0, ups = 0;

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or posedge rst_i);
      #1;
      if (rst_i) begin
        model_reset();
      end else begin
        model_edge(0, press_a);
        model_edge(1, press_z);
        m_lfsr = lfsr_next(m_lfsr);
        check("sw_a",    sw_a,    m_sw[0]);
        check("state_a", state_a, m_state[0]);
        check("busy_a",  busy_a,  m_busy[0]);
        check("done_a",  done_a,  m_done[0]);
        check("sw_z",    sw_z,    m_sw[1]);
        check("state_z", state_z, m_state[1]);
        check("busy_z",  busy_z,  m_busy[1]);
        check("done_z",  done_z,  m_done[1]);
        if (sw_a != db_last) begin
          db_last = sw_a;
          db_cnt  = 0;
        end else if (db_cnt < 1024) begin
          db_cnt++;
        end
        if (db_cnt == 1024 && sw_a != db_state) begin
          db_state = sw_a;
          if (!sw_a) downs++;
          else ups++;
        end
      end
    end
  end

  task automatic wait_done(input int d, input string name);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk_i);
      n++;
      if ((d == 0) ? done_a : done_z) break;
      if (n >= LIMIT) begin
        timeout(name);
        break;
      end
    end
  endtask

  // Observe one transition from the negedge where press was changed until done_o.
  task automatic measure(input int d, input string name, output int n_chg, output int cyc,
                         output int hold, output int smin, output int smax,
                         output int first_chg, output logic busy1);
    logic prev, cur;
    int   last;
    prev = (d == 0) ? sw_a : sw_z;
    n_chg = 0; cyc = 0; last = 0; smin = 1 << 30; smax = 0; first_chg = 0; busy1 = 1'b0;
    while (1) begin
      @(negedge clk_i);
      cyc++;
      cur = (d == 0) ? sw_a : sw_z;
      if (cyc == 1) busy1 = (d == 0) ? busy_a : busy_z;
      if (cur != prev) begin
        n_chg++;
        if (n_chg == 1) first_chg = cyc;
        else begin
          if (cyc - last < smin) smin = cyc - last;
          if (cyc - last > smax) smax = cyc - last;
        end
        last = cyc;
        prev = cur;
      end
      if ((d == 0) ? done_a : done_z) break;
      if (cyc >= LIMIT) begin
        timeout(name);
        break;
      end
    end
    hold = cyc - last;
  endtask

  task automatic check_bounce_a(input string name, input int n_chg, input int cyc,
                                input int hold, input int smin, input int smax);
    check({name, "_changes"}, n_chg, 2 * BA + 1);
    check({name, "_settle_hold"}, hold, SETTLE);
`ifdef BUTTON_BOUNCE_GEN_LFSR_EN
    check({name, "_seg_range"}, (smin >= 1 && smax <= 16), 1);
    check({name, "_latency"}, (cyc >= 2 * BA + SETTLE + 1 && cyc <= 32 * BA + SETTLE + 1), 1);
`else
    check({name, "_seg_min"}, smin, 8);
    check({name, "_seg_max"}, smax, 8);
    check({name, "_latency"}, cyc, 4 * 8 + SETTLE + 1);
`endif
  endtask

  initial begin
    int   n_chg, cyc, hold, smin, smax, first_chg;
    logic busy1;
    bit   cur;

    repeat (3) @(negedge clk_i);
    #1;
    check("rst_sw_a", sw_a, 1); check("rst_state_a", state_a, 0);
    check("rst_busy_a", busy_a, 0); check("rst_done_a", done_a, 0);
    check("rst_sw_z", sw_z, 1); check("rst_state_z", state_z, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Idle with no request
    repeat (100) @(negedge clk_i);
    check("idle_sw_a", sw_a, 1); check("idle_busy_a", busy_a, 0); check("idle_state_a", state_a, 0);

    // Press then release on the two-bounce instance
    press_a = 1'b1;
    measure(0, "press_a", n_chg, cyc, hold, smin, smax, first_chg, busy1);
    check("press_first_busy", busy1, 1);
    check("press_first_change", first_chg, 1);
    check_bounce_a("press", n_chg, cyc, hold, smin, smax);
    check("press_state", state_a, 1);
    check("press_sw_final", sw_a, 0);
    @(negedge clk_i);
    press_a = 1'b0;
    measure(0, "release_a", n_chg, cyc, hold, smin, smax, first_chg, busy1);
    check_bounce_a("release", n_chg, cyc, hold, smin, smax);
    check("release_state", state_a, 0);
    check("release_sw_final", sw_a, 1);

    // Request withdrawn mid-bounce: ignored until done, then a release starts next cycle
    @(negedge clk_i);
    press_a = 1'b1;
    repeat (4) @(negedge clk_i);
    press_a = 1'b0;
    wait_done(0, "midbounce_done");
    check("midbounce_state", state_a, 1);
    @(negedge clk_i);
    check("midbounce_restart_busy", busy_a, 1);
    check("midbounce_restart_done", done_a, 0);
    wait_done(0, "midbounce_release_done");
    check("midbounce_release_state", state_a, 0);

    // No-bounce instance: straight to the settled level
    @(negedge clk_i);
    press_z = 1'b1;
    measure(1, "press_z", n_chg, cyc, hold, smin, smax, first_chg, busy1);
    check("z_changes", n_chg, 1);
    check("z_first_change", first_chg, 1);
    check("z_latency", cyc, SETTLE + 1);
    check("z_state", state_z, 1);
    @(negedge clk_i);
    press_z = 1'b0;
    wait_done(1, "z_release_done");

    // Reset in the middle of SETTLE
    @(negedge clk_i);
    press_a = 1'b1;
    repeat (150) @(negedge clk_i);
    check("abort_in_settle_busy", busy_a, 1);
    rst_i = 1'b1;
    #1;
    check("abort_sw", sw_a, 1); check("abort_state", state_a, 0);
    check("abort_busy", busy_a, 0); check("abort_done", done_a, 0);
    repeat (2) begin
      @(negedge clk_i);
      check("abort_done_hold", done_a, 0);
    end
    rst_i = 1'b0;
    wait_done(0, "post_reset_done");
    check("post_reset_state", state_a, 1);
    cur = 1'b1;

    // Random transitions with ignored request glitches while busy
    for (int i = 0; i < 20; i++) begin
      int gap, g_at, g_len;
      gap = $urandom_range(0, 5);
      repeat (gap + 1) @(negedge clk_i);
      cur = ~cur;
      press_a = cur;
      press_z = 1'($urandom_range(0, 1));
      g_at  = $urandom_range(2, 40);
      g_len = $urandom_range(1, 20);
      repeat (g_at) @(negedge clk_i);
      press_a = ~cur;
      repeat (g_len) @(negedge clk_i);
      press_a = cur;
      wait_done(0, "rand_done");
      check("rand_state", state_a, cur);
    end

    press_z = 1'b0;
    repeat (SETTLE + 20) @(negedge clk_i);
    check("debounce_downs", downs, m_presses);
    check("debounce_ups", ups, m_releases);
    check("debounce_activity", (downs > 10), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
